// File: rtl/panda_shell_pkg.sv
// Shared constants and types for the PandA capture shell: register map,
// IRQ flag bit positions and fixed buffer/timestamp geometry.
package panda_shell_pkg;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int TS_W  = 26;
  localparam int TTL_W = 6;

  localparam logic [2:0] ADDR_CTRL         = 3'd0;
  localparam logic [2:0] ADDR_FRAMING_MASK = 3'd1;
  localparam logic [2:0] ADDR_BLOCK_SIZE   = 3'd2;
  localparam logic [2:0] ADDR_IRQ_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_SAMPLE_DATA  = 3'd4;
  localparam logic [2:0] ADDR_TTL_STATE    = 3'd5;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_DISARM = 1;

  localparam int FLAG_BLOCK     = 0;
  localparam int FLAG_COMPLETED = 1;
  localparam int FLAG_OVERFLOW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DONE
  } cap_state_e;

  // A programmed block size of 0 stands for a full buffer's worth.
  function automatic logic [5:0] block_limit(input logic [5:0] block_size);
    return (block_size == 6'd0) ? 6'(DEPTH) : block_size;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// 32x32 synchronous FIFO; a pop frees a slot in the same cycle, so push and
// pop together are accepted even when full.
module sample_fifo
  import panda_shell_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        full,
  output logic        empty
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/panda_top_tb_shell.sv
// PandA capture shell: synchronises TTL pads, timestamps framed rising edges
// into a sample FIFO and reports block/completion/overflow through an IRQ.
module panda_top_tb_shell
  import panda_shell_pkg::*;
(
  input  logic             FCLK,
  input  logic             tb_ARESETn,
  input  logic [TTL_W-1:0] ttlin_pad,
  input  logic             reg_wr,
  input  logic             reg_rd,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             irq
);

  logic [TTL_W-1:0] ttl_meta, ttl_sync, ttl_prev, rise;
  logic [5:0]       framing_mask, block_size, blk_cnt, blk_next;
  logic [TS_W-1:0]  ts;
  logic [7:0]       flags, flags_nxt, flag_set;
  logic [15:0]      smpl_count, count_base, count_nxt;
  logic [31:0]      fifo_rdata, rd_mux;
  logic             fifo_full, fifo_empty;
  logic             arm_req, disarm_req, do_arm, do_disarm, armed, completed;
  logic             push_req, pop_req, status_rd, blk_hit, overflow;
  cap_state_e       state, state_nxt;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata[31:6];

  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      ttl_meta <= '0;
      ttl_sync <= '0;
      ttl_prev <= '0;
    end else begin
      ttl_meta <= ttlin_pad;
      ttl_sync <= ttl_meta;
      ttl_prev <= ttl_sync;
    end
  end

  assign rise       = ttl_sync & ~ttl_prev;
  assign arm_req    = reg_wr && (reg_addr == ADDR_CTRL) && reg_wdata[CTRL_ARM];
  assign disarm_req = reg_wr && (reg_addr == ADDR_CTRL) && reg_wdata[CTRL_DISARM];
  assign status_rd  = reg_rd && (reg_addr == ADDR_IRQ_STATUS);
  assign pop_req    = reg_rd && (reg_addr == ADDR_SAMPLE_DATA);
  assign push_req   = armed && |(rise & framing_mask);
  // A full buffer still accepts a push when a pop frees the head the same cycle.
  assign overflow   = push_req && fifo_full && !pop_req;
  assign blk_next   = blk_cnt + 6'd1;
  assign blk_hit    = push_req && (blk_next >= block_limit(block_size));

  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARMED: if (disarm_req)               state_nxt = ST_DONE;
      default:  if (arm_req && !disarm_req)   state_nxt = ST_ARMED;
    endcase
  end

  always_comb begin
    armed     = (state == ST_ARMED);
    completed = (state == ST_DONE);
    do_arm    = (state != ST_ARMED) && arm_req && !disarm_req;
    do_disarm = (state == ST_ARMED) && disarm_req;
  end

  // Flags and count raised this cycle survive a same-cycle IRQ_STATUS clear.
  always_comb begin
    flag_set                 = '0;
    flag_set[FLAG_BLOCK]     = blk_hit;
    flag_set[FLAG_COMPLETED] = do_disarm;
    flag_set[FLAG_OVERFLOW]  = overflow;
    flags_nxt  = (status_rd ? 8'd0 : flags) | flag_set;
    count_base = status_rd ? 16'd0 : smpl_count;
    count_nxt  = (push_req && (count_base != 16'hFFFF)) ? count_base + 16'd1 : count_base;
  end

  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn) begin
      framing_mask <= '0;
      block_size   <= '0;
      ts           <= '0;
      blk_cnt      <= '0;
      flags        <= '0;
      smpl_count   <= '0;
      irq          <= 1'b0;
    end else begin
      if (reg_wr && (reg_addr == ADDR_FRAMING_MASK)) framing_mask <= reg_wdata[5:0];
      if (reg_wr && (reg_addr == ADDR_BLOCK_SIZE))   block_size   <= reg_wdata[5:0];
      if (do_arm)     ts <= '0;
      else if (armed) ts <= ts + 1'b1;
      if (do_arm)        blk_cnt <= '0;
      else if (push_req) blk_cnt <= blk_hit ? 6'd0 : blk_next;
      flags      <= flags_nxt;
      smpl_count <= count_nxt;
      irq        <= |flags;
    end
  end

  sample_fifo u_fifo (
    .clk   (FCLK),
    .rst_n (tb_ARESETn),
    .clr   (do_arm),
    .push  (push_req),
    .pop   (pop_req),
    .wdata ({ts, ttl_sync}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_CTRL:         rd_mux = {30'd0, completed, armed};
      ADDR_FRAMING_MASK: rd_mux = {26'd0, framing_mask};
      ADDR_BLOCK_SIZE:   rd_mux = {26'd0, block_size};
      ADDR_IRQ_STATUS:   rd_mux = {smpl_count, 8'd0, flags};
      ADDR_SAMPLE_DATA:  rd_mux = fifo_empty ? 32'd0 : fifo_rdata;
      ADDR_TTL_STATE:    rd_mux = {26'd0, ttl_sync};
      default:           rd_mux = '0;
    endcase
  end

  always_ff @(posedge FCLK or negedge tb_ARESETn) begin
    if (!tb_ARESETn)  reg_rdata <= '0;
    else if (reg_rd)  reg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_panda_top_tb_shell.sv
// Directed bench for the PandA capture shell: register reads are queued with
// their expected values and a monitor compares each one as its data returns.
module tb_panda_top_tb_shell;
  import panda_shell_pkg::*;

  logic        FCLK       = 1'b0;
  logic        tb_ARESETn = 1'b0;
  logic [5:0]  ttlin_pad  = '0;
  logic        reg_wr     = 1'b0;
  logic        reg_rd     = 1'b0;
  logic [2:0]  reg_addr   = '0;
  logic [31:0] reg_wdata  = '0;
  logic [31:0] reg_rdata;
  logic        irq;

  panda_top_tb_shell dut (
    .FCLK       (FCLK),
    .tb_ARESETn (tb_ARESETn),
    .ttlin_pad  (ttlin_pad),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq        (irq)
  );

  always #5 FCLK = ~FCLK;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  always @(posedge FCLK) cyc <= cyc + 1;

  // Scoreboard: expected read data and a label per outstanding read.
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  // Reference model of the capture state.
  logic [31:0] m_q[$];
  logic        m_armed = 1'b0;
  logic [5:0]  m_mask  = '0;
  int          arm_c   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  always @(posedge FCLK) rd_seen <= reg_rd;

  always @(negedge FCLK) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got 0x%08h, required no read data", reg_rdata);
      end else begin
        check(name_q.pop_front(), reg_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge FCLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge FCLK);
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    reg_rd = 1'b1; reg_addr = a;
    @(negedge FCLK);
    reg_rd = 1'b0;
  endtask

  task automatic set_mask(input logic [5:0] m);
    m_mask = m;
    wr(ADDR_FRAMING_MASK, {26'd0, m});
  endtask

  task automatic arm();
    if (!m_armed) begin
      m_armed = 1'b1;
      arm_c   = cyc;
      m_q.delete();
    end
    wr(ADDR_CTRL, 32'd1);
  endtask

  task automatic disarm();
    m_armed = 1'b0;
    wr(ADDR_CTRL, 32'd2);
  endtask

  // One-cycle pad pulse; returns on the cycle its sample has been pushed.
  // The pushed timestamp counts cycles from the arming edge to the detect cycle.
  task automatic pulse(input int b);
    int q;
    q = cyc;
    ttlin_pad[b] = 1'b1;
    if (m_armed && m_mask[b] && (m_q.size() < DEPTH))
      m_q.push_back({26'(q - arm_c + 1), 6'(1 << b)});
    @(negedge FCLK);
    ttlin_pad[b] = 1'b0;
    idle(2);
  endtask

  task automatic pop_expect(input string name);
    logic [31:0] e;
    e = (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
    rd(ADDR_SAMPLE_DATA, e, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    tb_ARESETn = 1'b1;
    idle(2);

    // Reset state
    check("irq_reset", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_reg%0d", a));
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'd0, "addr6_ignored");
    wr(ADDR_FRAMING_MASK, 32'hFFFF_FFFF);
    rd(ADDR_FRAMING_MASK, 32'h3F, "mask_width");

    // Two-flop synchroniser latency on TTL_STATE
    ttlin_pad = 6'h2A;
    rd(ADDR_TTL_STATE, 32'd0, "ttl_sync_lat0");
    rd(ADDR_TTL_STATE, 32'd0, "ttl_sync_lat1");
    rd(ADDR_TTL_STATE, 32'h2A, "ttl_sync_live");
    ttlin_pad = '0;
    idle(4);

    // Block of 4 on pad0
    set_mask(6'h01);
    wr(ADDR_BLOCK_SIZE, 32'hFFFF_FFC4);
    rd(ADDR_BLOCK_SIZE, 32'h04, "block_size_rw");
    arm();
    repeat (4) pulse(0);
    check("irq_lags_block", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_block", {31'd0, irq}, 32'd1);
    rd(ADDR_IRQ_STATUS, 32'h0004_0001, "status_block");
    for (int i = 0; i < 4; i++) pop_expect($sformatf("block_sample%0d", i));
    pop_expect("pop_empty");

    // DISARM timing and completion flag
    disarm();
    check("irq_lags_disarm", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_completed", {31'd0, irq}, 32'd1);
    rd(ADDR_IRQ_STATUS, 32'h0000_0002, "status_completed");

    // Two pad3 samples then DISARM
    set_mask(6'h08);
    arm();
    repeat (2) pulse(3);
    disarm();
    idle(1);
    rd(ADDR_IRQ_STATUS, 32'h0002_0002, "status_disarm");
    rd(ADDR_CTRL, 32'h2, "ctrl_completed");
    wr(ADDR_CTRL, 32'h3);
    rd(ADDR_CTRL, 32'h2, "ctrl_arm_disarm_same");
    rd(ADDR_IRQ_STATUS, 32'd0, "status_cleared");
    idle(3);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    // Unframed edges
    set_mask(6'h01);
    arm();
    rd(ADDR_CTRL, 32'h1, "ctrl_armed");
    repeat (2) pulse(1);
    rd(ADDR_IRQ_STATUS, 32'd0, "status_unframed");
    pop_expect("pop_unframed");

    // BLOCK_SIZE 0 means 32; the 33rd sample overflows
    wr(ADDR_BLOCK_SIZE, 32'd0);
    repeat (33) pulse(0);
    idle(1);
    check("irq_full", {31'd0, irq}, 32'd1);
    rd(ADDR_IRQ_STATUS, 32'h0021_0005, "status_overflow");
    for (int i = 0; i < DEPTH; i++) pop_expect($sformatf("full_sample%0d", i));
    pop_expect("pop_after_drain");

    // Reset mid-capture
    wr(ADDR_BLOCK_SIZE, 32'd1);
    pulse(0);
    idle(1);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    tb_ARESETn = 1'b0;
    m_armed = 1'b0;
    m_mask  = '0;
    m_q.delete();
    #1;
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    check("rdata_in_reset", reg_rdata, 32'd0);
    idle(2);
    tb_ARESETn = 1'b1;
    idle(1);
    rd(ADDR_CTRL, 32'd0, "ctrl_after_reset");
    repeat (2) pulse(0);
    rd(ADDR_IRQ_STATUS, 32'd0, "status_after_reset");
    pop_expect("pop_after_reset");
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
